// File: rtl/gpr_multiport_pkg.sv
// Shared widths, zero-register index and write-port priority resolution for gpr_multiport.
package gpr_multiport_pkg;

    localparam int GPR_ADDR_W   = 5;
    localparam int GPR_DATA_W   = 32;
    localparam int GPR_MAX_WR   = 3;
    localparam int GPR_ZERO_REG = 0;

    // One-hot grant of the highest-index matching write port (higher index wins).
    function automatic logic [GPR_MAX_WR-1:0] gpr_win_port(input logic [GPR_MAX_WR-1:0] match);
        logic [GPR_MAX_WR-1:0] grant;
        grant = '0;
        for (int p = 0; p < GPR_MAX_WR; p++) begin
            if (match[p]) begin
                grant    = '0;
                grant[p] = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/gpr_multiport_if.sv
// Read/write/issue/debug bundle between the pipeline (master) and the register file (slave).
interface gpr_multiport_if import gpr_multiport_pkg::*; #(
    parameter int ADDR_WIDTH = GPR_ADDR_W,
    parameter int DATA_WIDTH = GPR_DATA_W,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 2
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [NUM_RD-1:0][ADDR_WIDTH-1:0] rd_addr;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_data;
    logic [NUM_RD-1:0]                 rd_busy;
    logic [NUM_WR-1:0]                 wr_en;
    logic [NUM_WR-1:0][ADDR_WIDTH-1:0] wr_addr;
    logic [NUM_WR-1:0][DATA_WIDTH-1:0] wr_data;
    logic                              iss_valid;
    logic [ADDR_WIDTH-1:0]             iss_rd;
    logic                              any_busy;
    logic [DEPTH-1:0][DATA_WIDTH-1:0]  dbg_rf;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_valid, iss_rd,
        input  rd_data, rd_busy, any_busy, dbg_rf
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_valid, iss_rd,
        output rd_data, rd_busy, any_busy, dbg_rf
    );

endinterface

// File: rtl/gpr_multiport_wr_arbiter.sv
// Resolves which write port (if any) targets one register index and selects its data.
module gpr_wr_arbiter import gpr_multiport_pkg::*; #(
    parameter int ADDR_WIDTH = GPR_ADDR_W,
    parameter int DATA_WIDTH = GPR_DATA_W,
    parameter int NUM_WR     = 2
) (
    input  logic [NUM_WR-1:0]                 wr_en,
    input  logic [NUM_WR-1:0][ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_WR-1:0][DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0]             target,
    output logic                              hit,
    output logic [DATA_WIDTH-1:0]             data
);
    logic [GPR_MAX_WR-1:0] match;
    logic [GPR_MAX_WR-1:0] grant;

    always_comb begin
        match = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            match[p] = wr_en[p] && (wr_addr[p] == target);
        end
        grant = gpr_win_port(match);
        hit   = |grant;
        data  = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            if (grant[p]) data = wr_data[p];
        end
    end

endmodule

// File: rtl/gpr_multiport.sv
// Multiport GPR file with busy scoreboard and debug view.
// Define GPR_BYPASS_EN for write-first read-during-write forwarding on the read ports.
module gpr_multiport import gpr_multiport_pkg::*; #(
    parameter int ADDR_WIDTH = GPR_ADDR_W,
    parameter int DATA_WIDTH = GPR_DATA_W,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    gpr_multiport_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DEPTH-1:0][DATA_WIDTH-1:0] regs;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] wr_sel;
    logic [DEPTH-1:0]                 busy;
    logic [DEPTH-1:0]                 wr_hit;
    logic [DEPTH-1:0]                 iss_hit;

    // x0 has no write decoder and no issue decode, so it stays zero and never busy.
    assign wr_hit[GPR_ZERO_REG]  = 1'b0;
    assign wr_sel[GPR_ZERO_REG]  = '0;
    assign iss_hit[GPR_ZERO_REG] = 1'b0;

    for (genvar i = GPR_ZERO_REG + 1; i < DEPTH; i++) begin : g_reg
        gpr_wr_arbiter #(
            .ADDR_WIDTH(ADDR_WIDTH),
            .DATA_WIDTH(DATA_WIDTH),
            .NUM_WR    (NUM_WR)
        ) u_arb (
            .wr_en  (bus.wr_en),
            .wr_addr(bus.wr_addr),
            .wr_data(bus.wr_data),
            .target (ADDR_WIDTH'(i)),
            .hit    (wr_hit[i]),
            .data   (wr_sel[i])
        );
        assign iss_hit[i] = bus.iss_valid && (bus.iss_rd == ADDR_WIDTH'(i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
            busy <= '0;
        end else begin
            for (int i = GPR_ZERO_REG + 1; i < DEPTH; i++) begin
                if (wr_hit[i]) regs[i] <= wr_sel[i];
                // A new producer supersedes the one retiring this cycle.
                if (iss_hit[i])     busy[i] <= 1'b1;
                else if (wr_hit[i]) busy[i] <= 1'b0;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        assign addr = bus.rd_addr[k];
`ifdef GPR_BYPASS_EN
        logic                  byp_hit;
        logic [DATA_WIDTH-1:0] byp_data;
        logic                  fwd;

        gpr_wr_arbiter #(
            .ADDR_WIDTH(ADDR_WIDTH),
            .DATA_WIDTH(DATA_WIDTH),
            .NUM_WR    (NUM_WR)
        ) u_byp (
            .wr_en  (bus.wr_en),
            .wr_addr(bus.wr_addr),
            .wr_data(bus.wr_data),
            .target (addr),
            .hit    (byp_hit),
            .data   (byp_data)
        );

        assign fwd            = byp_hit && (addr != ADDR_WIDTH'(GPR_ZERO_REG));
        assign bus.rd_data[k] = fwd ? byp_data : regs[addr];
        // Retiring producer clears busy early unless a new one is issued on the same edge.
        assign bus.rd_busy[k] = busy[addr] && !(fwd && !iss_hit[addr]);
`else
        assign bus.rd_data[k] = regs[addr];
        assign bus.rd_busy[k] = busy[addr];
`endif
    end

    assign bus.any_busy = |busy;
    assign bus.dbg_rf   = regs;

endmodule

// File: tb/tb_gpr_multiport.sv
// Scoreboard bench for gpr_multiport: directed cases plus randomized traffic against a reference model.
module tb_gpr_multiport;
    import gpr_multiport_pkg::*;

    localparam int AW    = 5;
    localparam int DW    = 64;
    localparam int NR    = 4;
    localparam int NW    = 3;
    localparam int DEPTH = 1 << AW;
`ifdef GPR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gpr_multiport_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .NUM_WR(NW)) bus ();

    gpr_multiport #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .NUM_WR(NW)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic [NR-1:0][DW-1:0]    data;
        logic [NR-1:0]            busy;
        logic                     any;
        logic [DEPTH-1:0][DW-1:0] dbg;
        string                    tag;
    } exp_t;

    exp_t q[$];
    event smp;
    int   checks   = 0;
    int   failures = 0;

    logic [DW-1:0] mreg [DEPTH];
    bit            mbusy[DEPTH];

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            mreg[i]  = '0;
            mbusy[i] = 1'b0;
        end
    endtask

    // Expected outputs for the inputs currently applied.
    function automatic exp_t predict(string tag);
        exp_t e;
        e.tag = tag;
        for (int k = 0; k < NR; k++) begin
            int a   = int'(bus.rd_addr[k]);
            int win = -1;
            for (int p = 0; p < NW; p++)
                if (bus.wr_en[p] && int'(bus.wr_addr[p]) == a) win = p;
            e.data[k] = mreg[a];
            e.busy[k] = mbusy[a];
            if (BYP && a != 0 && win >= 0) begin
                e.data[k] = bus.wr_data[win];
                if (!(bus.iss_valid && int'(bus.iss_rd) == a)) e.busy[k] = 1'b0;
            end
        end
        e.any = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            e.any    = e.any | mbusy[i];
            e.dbg[i] = mreg[i];
        end
        return e;
    endfunction

    // Clock-edge effect of the held inputs: ascending port order makes the highest port win.
    task automatic model_commit();
        for (int p = 0; p < NW; p++) begin
            int a = int'(bus.wr_addr[p]);
            if (bus.wr_en[p] && a != 0) begin
                mreg[a]  = bus.wr_data[p];
                mbusy[a] = 1'b0;
            end
        end
        if (bus.iss_valid && bus.iss_rd != '0) mbusy[int'(bus.iss_rd)] = 1'b1;
    endtask

    task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        int   bad;
        forever begin
            @(negedge clk or smp);
            while (q.size() > 0) begin
                e = q.pop_front();
                for (int k = 0; k < NR; k++) begin
                    chk($sformatf("%s rd_data[%0d]", e.tag, k), bus.rd_data[k], e.data[k]);
                    chk($sformatf("%s rd_busy[%0d]", e.tag, k), DW'(bus.rd_busy[k]), DW'(e.busy[k]));
                end
                chk($sformatf("%s any_busy", e.tag), DW'(bus.any_busy), DW'(e.any));
                checks++;
                bad = -1;
                for (int i = 0; i < DEPTH; i++)
                    if (bus.dbg_rf[i] !== e.dbg[i] && bad < 0) bad = i;
                if (bad >= 0) begin
                    failures++;
                    if (failures <= 40)
                        $display("FAIL %s dbg_rf[%0d]: got %h expected %h", e.tag, bad, bus.dbg_rf[bad], e.dbg[bad]);
                end
            end
        end
    end

    task automatic idle();
        bus.wr_en     = '0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.iss_valid = 1'b0;
        bus.iss_rd    = '0;
    endtask

    task automatic set_rd(int a0, int a1, int a2, int a3);
        bus.rd_addr[0] = AW'(a0);
        bus.rd_addr[1] = AW'(a1);
        bus.rd_addr[2] = AW'(a2);
        bus.rd_addr[3] = AW'(a3);
    endtask

    task automatic wr(int p, int a, logic [DW-1:0] d);
        bus.wr_en[p]   = 1'b1;
        bus.wr_addr[p] = AW'(a);
        bus.wr_data[p] = d;
    endtask

    // Entered and left just after a rising edge with inputs stable.
    task automatic step(string tag);
        q.push_back(predict(tag));
        @(negedge clk);
        @(posedge clk);
        model_commit();
        #1;
    endtask

    // Asynchronous reset pulse in the middle of the cycle, checked before any clock edge.
    task automatic reset_pulse(string tag);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        q.push_back(predict(tag));
        ->smp;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    function automatic logic [AW-1:0] rnd_addr(bit narrow);
        return narrow ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, DEPTH-1));
    endfunction

    initial begin : watchdog
        #500000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : stim
        bit narrow;
        idle();
        set_rd(0, 1, 2, 3);
        model_reset();
        @(posedge clk);
        #1;
        q.push_back(predict("por"));
        ->smp;
        #1 rst_n = 1'b1;

        // Write x5 then reset asynchronously.
        idle(); wr(0, 5, 64'h1234); set_rd(5, 0, 5, 1);
        step("wr_x5");
        idle();
        step("rd_x5");
        reset_pulse("rst_async");

        // Same-edge write conflict: port1 outranks port0.
        idle(); wr(0, 7, 64'hAAAA); wr(1, 7, 64'h5555); set_rd(7, 7, 0, 7);
        step("conflict");
        idle();
        step("conflict_next");

        // Writes and issue to x0 are ignored.
        idle(); wr(0, 0, '1); wr(2, 0, '1); bus.iss_valid = 1'b1; bus.iss_rd = '0; set_rd(0, 0, 0, 0);
        step("x0_wr");
        idle();
        step("x0_next");

        // Scoreboard: set, set-beats-clear, clear.
        idle(); bus.iss_valid = 1'b1; bus.iss_rd = AW'(3); set_rd(3, 3, 0, 4);
        step("iss_x3");
        idle();
        step("x3_busy");
        wr(1, 3, 64'h33); bus.iss_valid = 1'b1; bus.iss_rd = AW'(3);
        step("wr_iss_x3");
        idle();
        step("x3_still");
        wr(2, 3, 64'h44);
        step("wr_x3");
        idle();
        step("x3_free");

        // Read-during-write on x9.
        idle(); wr(0, 9, 64'h1111); set_rd(9, 9, 9, 9);
        step("x9_old");
        idle(); bus.iss_valid = 1'b1; bus.iss_rd = AW'(9);
        step("x9_iss");
        idle(); wr(1, 9, 64'hCAFE);
        step("byp_x9");
        idle();
        step("x9_after");

        // Randomized traffic, narrow index ranges half the time to force collisions.
        for (int c = 0; c < 10000; c++) begin
            narrow = ($urandom_range(0, 1) == 1);
            for (int k = 0; k < NR; k++) bus.rd_addr[k] = rnd_addr(narrow);
            for (int p = 0; p < NW; p++) begin
                bus.wr_en[p]   = ($urandom_range(0, 2) == 0);
                bus.wr_addr[p] = rnd_addr(narrow);
                bus.wr_data[p] = {$urandom, $urandom};
            end
            bus.iss_valid = ($urandom_range(0, 2) == 0);
            bus.iss_rd    = rnd_addr(narrow);
            if ($urandom_range(0, 499) == 0) reset_pulse("rand_rst");
            else step("rand");
        end

        idle();
        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected entries never compared", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
